uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver: 8N1 frames (1 start bit low, 8 data bits LSB first, 1 stop bit high) on an asynchronous `rx` line become a byte plus a ready flag. It sits directly downstream of the UART transmitter on the serial link and feeds the host-side byte consumer. Reception is driven by a 16x-oversampling tick from the shared baud generator. Each bit is sampled once, at mid-bit.

## Interface
- No parameters. Frame format is fixed: 8N1, 16 ticks per bit.
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `enb`  in  1  oversampling tick, one `clk` wide, 16 per bit period
- `rx`  in  1  asynchronous serial input; idle high
- `rdy_clr`  in  1  consumer acknowledge; clears `rdy` and `overrun`
- `data_out`  out  8  last correctly framed byte
- `rdy`  out  1  a byte is available in `data_out`
- `frame_err`  out  1  last frame had a low stop bit
- `overrun`  out  1  a new byte arrived while `rdy` was still set
- `busy`  out  1  receiver is not in IDLE (combinational)

## Operation
- Input synchronizer:
  - Two flops on `rx`, both reset to 1.
  - All decisions use the second flop output, `rx_s`.
- Internal state:
  - `state`: 2 bits.
  - `sample`: 4-bit tick counter.
  - `bit_idx`: 3 bits.
  - `shreg`: 8 bits.
- State machine (all transitions below happen only on cycles where `enb`=1):
  - **IDLE**: `sample`←0, `bit_idx`←0. If `rx_s`=0, go to START.
  - **START**:
    - When `sample`≠7: `sample`++.
    - When `sample`=7 (mid start bit) and `rx_s`=0: `sample`←0, go to DATA.
    - When `sample`=7 and `rx_s`=1: glitch, go to IDLE. No flags change.
  - **DATA**:
    - When `sample`≠15: `sample`++.
    - When `sample`=15: `shreg[bit_idx]`←`rx_s`, `sample`←0.
    - On that same sample, if `bit_idx`=7 go to STOP; otherwise `bit_idx`++.
  - **STOP**:
    - When `sample`≠15: `sample`++.
    - When `sample`=15 and `rx_s`=1: `data_out`←`shreg`, `rdy`←1, `frame_err`←0.
      - If `rdy` was already 1, also `overrun`←1.
    - When `sample`=15 and `rx_s`=0: `frame_err`←1. `data_out`, `rdy` and `overrun` are unchanged.
    - Either outcome: go to IDLE.
  - Undefined state encoding: go to IDLE.
- Flag rules:
  - `rdy_clr`=1 clears `rdy` and `overrun` on the next edge.
  - If `rdy_clr` and a new byte completion fall in the same cycle, the set wins: `rdy`=1, and `overrun`=1 if `rdy` was previously 1.
  - `frame_err` holds until the next completed frame. It is not cleared by `rdy_clr`.
- No receive buffering beyond `data_out`. On overrun the new byte overwrites the old one.

## Timing
- Reset values:
  - Outputs: `data_out`=0x00, `rdy`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - Internal: `state`=IDLE, `sample`=0, `bit_idx`=0, `shreg`=0, synchronizer flops = 1.
- Reset mid-frame aborts the frame immediately. The receiver returns to IDLE with all outputs at their reset values.
- `rx` to `rx_s` latency: 2 `clk` cycles.
- Start detect: the first `enb` tick that sees `rx_s`=0 while in IDLE.
- Start validation: 8 ticks after start detect.
- Data bit n (n = 0..7) is sampled 16·(n+1) ticks after start validation.
- Stop bit is sampled 144 ticks after start validation, i.e. 152 ticks after start detect.
- `rdy`, `data_out` and `frame_err` update on the `clk` edge of the stop-sample tick and are visible the following cycle.
- `busy` is high from the edge after start detect until the edge after the stop sample.
- The receiver re-arms in IDLE on the tick after the stop sample, so back-to-back frames with a one-bit stop are received.
- Tolerated baud mismatch: about ±3%, from mid-bit sampling.
- `enb`=0 freezes all counters and state.

## Test plan
- Reset, then an 8N1 frame 0xA5 with exact 16x timing → `rdy`=1 and `data_out`=0xA5 152 ticks after start detect; `frame_err`=0, `overrun`=0.
- 4-tick low pulse on idle `rx` → START entered, rejected at `sample`=7, back to IDLE; `rdy`, `frame_err` and `data_out` unchanged.
- Frame 0x3C with the stop bit held low → `frame_err`=1, `rdy`=0, `data_out` keeps its previous value. A following good frame 0x81 → `frame_err`=0, `rdy`=1, `data_out`=0x81.
- Two back-to-back frames 0x11 then 0x22 with no `rdy_clr` → `data_out`=0x22, `rdy`=1, `overrun`=1. `rdy_clr` pulse → `rdy`=0, `overrun`=0.
- `rdy_clr` asserted in the same cycle a new byte 0x5A completes → `rdy` stays 1 and `data_out`=0x5A.
- Assert `rst` during data bit 4 of 0xFF → all outputs at reset values next cycle. A subsequent frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and mid-bit sampling
//
// Purpose: turns an asynchronous 8N1 serial stream into a byte plus a ready flag.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   enb       in  oversampling tick, one clk wide, 16 per bit period
//   rx        in  asynchronous serial input, idle high
//   rdy_clr   in  consumer acknowledge, clears rdy and overrun
//   data_out  out last correctly framed byte
//   rdy       out a byte is available in data_out
//   frame_err out last frame had a low stop bit
//   overrun   out a new byte arrived while rdy was still set
//   busy      out receiver is not idle
module uart_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] sample, sample_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] data_n;
  logic       rdy_n, frame_err_n, overrun_n;

  // Two-flop synchronizer; both flops reset to the idle line level so a
  // reset never looks like a start bit.
  logic rx_m, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sample    <= 4'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      sample    <= sample_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      rdy       <= rdy_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    sample_n    = sample;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data_out;
    rdy_n       = rdy;
    frame_err_n = frame_err;
    overrun_n   = overrun;

    // Acknowledge first, so a byte completing in the same cycle overrides it.
    if (rdy_clr) begin
      rdy_n     = 1'b0;
      overrun_n = 1'b0;
    end

    if (enb) begin
      case (state)
        IDLE: begin
          sample_n  = 4'd0;
          bit_idx_n = 3'd0;
          if (!rx_s) begin
            state_n = START;
          end
        end

        START: begin
          if (sample != 4'd7) begin
            sample_n = sample + 4'd1;
          end else if (!rx_s) begin
            // Still low at mid start bit: align the counter to bit centres.
            sample_n = 4'd0;
            state_n  = DATA;
          end else begin
            // Glitch shorter than half a bit; IDLE clears the counter.
            state_n = IDLE;
          end
        end

        DATA: begin
          if (sample != 4'd15) begin
            sample_n = sample + 4'd1;
          end else begin
            shreg_n[bit_idx] = rx_s;
            sample_n         = 4'd0;
            if (bit_idx == 3'd7) begin
              state_n = STOP;
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end
        end

        STOP: begin
          if (sample != 4'd15) begin
            sample_n = sample + 4'd1;
          end else begin
            if (rx_s) begin
              data_n      = shreg;
              rdy_n       = 1'b1;
              frame_err_n = 1'b0;
              // Uses the registered rdy: an acknowledge in this same cycle
              // does not hide the fact that the old byte was never taken.
              if (rdy) begin
                overrun_n = 1'b1;
              end
            end else begin
              frame_err_n = 1'b1;
            end
            sample_n = 4'd0;
            state_n  = IDLE;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int div = 0;

  uart_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data_out  (data_out),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One enb tick every TICK_DIV clocks, changed on the falling edge.
  always @(negedge clk) begin
    div = (div + 1) % TICK_DIV;
    enb = (div == 0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n enb ticks; returns 1 time unit after the last ticking edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!enb) @(posedge clk);
    end
    #1;
  endtask

  // Start bit plus 8 data bits (144 ticks); leaves rx high for the stop bit.
  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_head(b);
    rx = stop_bit;
    tick(16);
    rx = 1'b1;
  endtask

  task automatic ack();
    rdy_clr = 1'b1;
    tick(1);
    rdy_clr = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_rdy", {7'd0, rdy}, 8'h00);
    chk("rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    tick(4);

    // Frame 0xA5, exact timing: stop sample is 152 ticks after start detect
    rx = 1'b0;
    tick(1);
    chk("a5_busy_after_detect", {7'd0, busy}, 8'h01);
    tick(15);
    for (int i = 0; i < 8; i++) begin
      rx = (8'hA5 >> i) & 1'b1;
      tick(16);
    end
    rx = 1'b1;
    tick(8);
    chk("a5_rdy_before_stop", {7'd0, rdy}, 8'h00);
    tick(1);
    chk("a5_rdy", {7'd0, rdy}, 8'h01);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_ferr", {7'd0, frame_err}, 8'h00);
    chk("a5_ovr", {7'd0, overrun}, 8'h00);
    tick(7);

    // 4-tick glitch: rejected at mid start bit
    rx = 1'b0;
    tick(1);
    chk("glitch_busy", {7'd0, busy}, 8'h01);
    tick(3);
    rx = 1'b1;
    tick(8);
    chk("glitch_idle", {7'd0, busy}, 8'h00);
    chk("glitch_rdy", {7'd0, rdy}, 8'h01);
    chk("glitch_data", data_out, 8'hA5);
    chk("glitch_ferr", {7'd0, frame_err}, 8'h00);

    ack();
    chk("ack_rdy", {7'd0, rdy}, 8'h00);

    // Frame 0x3C with low stop bit, then good frame 0x81
    send_frame(8'h3C, 1'b0);
    tick(16);
    chk("bad_ferr", {7'd0, frame_err}, 8'h01);
    chk("bad_rdy", {7'd0, rdy}, 8'h00);
    chk("bad_data", data_out, 8'hA5);
    chk("bad_busy", {7'd0, busy}, 8'h00);
    send_frame(8'h81, 1'b1);
    chk("81_ferr", {7'd0, frame_err}, 8'h00);
    chk("81_rdy", {7'd0, rdy}, 8'h01);
    chk("81_data", data_out, 8'h81);
    chk("81_ovr", {7'd0, overrun}, 8'h00);

    // Back-to-back 0x11, 0x22 without acknowledge -> overrun
    ack();
    send_frame(8'h11, 1'b1);
    chk("11_data", data_out, 8'h11);
    chk("11_ovr", {7'd0, overrun}, 8'h00);
    send_frame(8'h22, 1'b1);
    chk("22_data", data_out, 8'h22);
    chk("22_rdy", {7'd0, rdy}, 8'h01);
    chk("22_ovr", {7'd0, overrun}, 8'h01);
    ack();
    chk("ack2_rdy", {7'd0, rdy}, 8'h00);
    chk("ack2_ovr", {7'd0, overrun}, 8'h00);

    // Acknowledge coincides with completion of 0x5A while 0x33 is pending
    send_frame(8'h33, 1'b1);
    chk("33_rdy", {7'd0, rdy}, 8'h01);
    send_head(8'h5A);
    tick(8);
    chk("5a_pre_rdy", {7'd0, rdy}, 8'h01);
    chk("5a_pre_data", data_out, 8'h33);
    repeat (TICK_DIV - 1) @(posedge clk);
    #1;
    rdy_clr = 1'b1;
    @(posedge clk);
    #1;
    rdy_clr = 1'b0;
    chk("5a_rdy", {7'd0, rdy}, 8'h01);
    chk("5a_data", data_out, 8'h5A);
    chk("5a_ovr", {7'd0, overrun}, 8'h01);
    tick(7);

    // Reset during data bit 4 of 0xFF, then frame 0x0F
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(64 + 8);
    chk("mid_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_rdy", {7'd0, rdy}, 8'h00);
    chk("mid_rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("mid_rst_ovr", {7'd0, overrun}, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    tick(24);
    send_frame(8'h0F, 1'b1);
    chk("0f_data", data_out, 8'h0F);
    chk("0f_rdy", {7'd0, rdy}, 8'h01);
    chk("0f_ferr", {7'd0, frame_err}, 8'h00);
    chk("0f_ovr", {7'd0, overrun}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
